ps_packet_arbiter: RTL and testbench
====================================

# ps_packet_arbiter

Packet-level round-robin arbiter that shares one PacketStream output, typically the input of a `ps_head_inserter`, between `INPUTS` PacketStream sources. Grants are switched only at packet boundaries, so packets are never interleaved. Arbitration adds no cycle of latency. The block also provides the granted channel index and a start-of-packet flag. Downstream header logic uses these to build and insert per-source headers.

## Interface
Parameters:
- `WIDTH`, 8, data width of every stream.
- `INPUTS`, 4, number of requesting streams (≥2).
- `CW`, `$clog2(INPUTS)` (derived localparam), width of `o_chn`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset); one clock.
- `i_dat`  in  `INPUTS*WIDTH`  input data; input k occupies bits `[k*WIDTH +: WIDTH]`.
- `i_val`  in  `INPUTS`  per-input valid.
- `i_eop`  in  `INPUTS`  per-input end of packet.
- `i_rdy`  out  `INPUTS`  per-input ready.
- `o_dat`  out  `WIDTH`  output data.
- `o_val`  out  1  output valid.
- `o_eop`  out  1  output end of packet.
- `o_sop`  out  1  current output beat is the first beat of a packet.
- `o_chn`  out  `CW`  index of the granted input; meaningful while `o_val`=1.
- `o_rdy`  in  1  output ready.

## Operation
- Transfer on any stream happens in a cycle where `val & rdy` = 1. Sources hold `dat`, `val` and `eop` until accepted.
- Registers:
  - `state`: IDLE or LOCKED.
  - `grant_reg` [CW].
  - `last_reg` [CW]: last input granted.
  - `sop_reg`.
- IDLE, combinational pick:
  - `winner` = first k with `i_val[k]`=1, searching `last_reg+1`, `last_reg+2`, … modulo `INPUTS`.
  - `last_reg` itself is searched last.
  - If no input is valid, there is no winner.
- Current grant `g` = `grant_reg` in LOCKED, and `winner` in IDLE.
- Datapath:
  - `o_dat` = `i_dat[g]`.
  - `o_val` = `i_val[g]` (0 if IDLE with no winner).
  - `o_eop` = `o_val & i_eop[g]`.
  - `o_chn` = `g`.
  - `o_sop` = `o_val & sop_reg`.
  - `i_rdy[k]` = `o_rdy & (k==g)` when a grant exists, else 0.
  - `o_val` never depends on `o_rdy`.
- IDLE → LOCKED: when `o_val`=1 and NOT (`o_rdy & o_eop`). Set `grant_reg` = `winner` so that a presented-but-stalled beat cannot be re-arbitrated.
- IDLE, single-beat packet accepted (`o_val & o_rdy & o_eop`): stay in IDLE and set `last_reg` = `winner`.
- LOCKED → IDLE: on an accepted beat with `o_eop`=1. Set `last_reg` = `grant_reg`.
- LOCKED, otherwise: hold. `i_val[g]` dropping mid-packet only stalls the output; it never releases the grant.
- `sop_reg`: on an accepted beat, load `o_eop`; otherwise hold.
- Reset (`reset`=0 at a clock edge):
  - `state` = IDLE, `last_reg` = `INPUTS-1` (input 0 has first priority), `grant_reg` = 0, `sop_reg` = 1.
  - While `reset`=0, force `o_val`=0 and `i_rdy`=0 regardless of inputs.
  - Reset mid-packet abandons the packet; no eop is generated.

## Timing
- Zero latency: data, valid and eop pass combinationally from the granted input to the output. Throughput is 1 beat/clock.
- No idle cycle between packets. The beat after an accepted eop may come from a new winner in the same cycle the state returns to IDLE.
- Out of reset (first edge with `reset`=1): `o_val`=0 until some `i_val` is 1.
- Grant change happens only on the clock edge that accepts an eop beat.
- Fairness: with all inputs continuously valid, packets go 0,1,…,INPUTS-1,0,… Any requesting input waits at most `INPUTS-1` packets.

## Test plan
- Reset then input 2 sends 3 beats A,B,C (eop on C), `o_rdy`=1 → output A,B,C on consecutive cycles, `o_chn`=2, `o_sop`=1 only on A, `i_rdy`=0b0100 throughout.
- All 4 inputs continuously valid, each sending 2-beat packets, `o_rdy`=1 → `o_chn` sequence 0,0,1,1,2,2,3,3,0,0 with no gaps and no interleaving.
- Input 1 presents its first beat with `o_rdy`=0 for 3 cycles, and input 0 asserts val during the stall → output stays on input 1, `o_dat` stable, `i_rdy[0]`=0; input 1's packet completes first.
- Input 3 is mid-packet when `i_val[3]` drops for 2 cycles while input 0 is valid → `o_val`=0 for 2 cycles, grant stays 3, input 0 is served only after input 3's eop.
- Back-to-back single-beat packets from inputs 0 and 1 → beats accepted on consecutive cycles, `o_sop`=`o_eop`=1 on each, `o_chn` 0 then 1.
- `reset`=0 for one cycle in the middle of a packet from input 2 → `o_val`=`i_rdy`=0 in that cycle; afterwards, with inputs 0 and 2 valid, input 0 wins and `o_sop`=1.

Source files
------------

// File: rtl/ps_packet_arbiter.sv
// rtl/ps_packet_arbiter.sv - packet-level round-robin arbiter with zero-latency datapath
module ps_packet_arbiter #(
    parameter int  WIDTH  = 8,
    parameter int  INPUTS = 4,
    localparam int CW     = $clog2(INPUTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [INPUTS*WIDTH-1:0]   i_dat,
    input  logic [INPUTS-1:0]         i_val,
    input  logic [INPUTS-1:0]         i_eop,
    output logic [INPUTS-1:0]         i_rdy,
    output logic [WIDTH-1:0]          o_dat,
    output logic                      o_val,
    output logic                      o_eop,
    output logic                      o_sop,
    output logic [CW-1:0]             o_chn,
    input  logic                      o_rdy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   last_q, last_d;
    logic            sop_q, sop_d;

    logic [CW-1:0]   winner;
    logic [CW-1:0]   cand;
    logic            win_found;
    logic [CW-1:0]   g;
    logic            have_grant;
    logic            accept;

    // Walk from the farthest offset down so the nearest requester after last_q wins.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int off = INPUTS; off >= 1; off--) begin
            cand = CW'((int'(last_q) + off) % INPUTS);
            if (i_val[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    assign g          = (state_q == LOCKED) ? grant_q : winner;
    assign have_grant = reset && ((state_q == LOCKED) || win_found);
    assign o_dat      = i_dat[g*WIDTH +: WIDTH];
    assign o_val      = have_grant && i_val[g];
    assign o_eop      = o_val && i_eop[g];
    assign o_sop      = o_val && sop_q;
    assign o_chn      = g;
    assign accept     = o_val && o_rdy;

    always_comb begin
        for (int k = 0; k < INPUTS; k++) begin
            i_rdy[k] = have_grant && o_rdy && (g == CW'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        sop_d   = sop_q;
        if (accept) begin
            sop_d = o_eop;
        end
        case (state_q)
            IDLE: begin
                if (o_val) begin
                    if (o_rdy && o_eop) begin
                        last_d = winner;
                    end else begin
                        // A presented beat commits the grant even while stalled.
                        state_d = LOCKED;
                        grant_d = winner;
                    end
                end
            end
            LOCKED: begin
                if (accept && o_eop) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= CW'(INPUTS - 1);
            sop_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            sop_q   <= sop_d;
        end
    end

endmodule

// File: tb/tb_ps_packet_arbiter.sv
// tb/tb_ps_packet_arbiter.sv - randomized scoreboard bench for ps_packet_arbiter
module tb_ps_packet_arbiter;

    localparam int WIDTH  = 8;
    localparam int INPUTS = 4;
    localparam int CW     = 2;
    localparam int CYCLES = 4000;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [INPUTS*WIDTH-1:0] i_dat = '0;
    logic [INPUTS-1:0]       i_val = '0;
    logic [INPUTS-1:0]       i_eop = '0;
    logic [INPUTS-1:0]       i_rdy;
    logic [WIDTH-1:0]        o_dat;
    logic                    o_val;
    logic                    o_eop;
    logic                    o_sop;
    logic [CW-1:0]           o_chn;
    logic                    o_rdy = 1'b0;

    ps_packet_arbiter #(.WIDTH(WIDTH), .INPUTS(INPUTS)) dut (
        .clk(clk), .reset(reset),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_sop(o_sop),
        .o_chn(o_chn), .o_rdy(o_rdy)
    );

    always #5 clk = ~clk;

    // beat = {eop, data}
    logic [WIDTH:0] src_q [INPUTS][$];
    logic [WIDTH:0] exp_q [INPUTS][$];

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    logic [INPUTS-1:0] acc_mask = '0;

    // Reference: a packet owns the output from its first presented beat until its eop is taken.
    bit in_pkt  = 1'b0;
    int owner   = 0;
    int last_ch = INPUTS - 1;
    bit first   = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        int g;
        bit have;
        logic [WIDTH:0] head;
        forever begin
            @(negedge clk);
            acc_mask = '0;
            if (!reset) begin
                chk("rst_o_val", 32'(o_val), 32'd0);
                chk("rst_i_rdy", 32'(i_rdy), 32'd0);
                in_pkt  = 1'b0;
                last_ch = INPUTS - 1;
                first   = 1'b1;
            end else begin
                have = in_pkt;
                g    = owner;
                if (!in_pkt) begin
                    for (int off = 1; off <= INPUTS; off++) begin
                        if (!have && i_val[(last_ch + off) % INPUTS]) begin
                            have = 1'b1;
                            g    = (last_ch + off) % INPUTS;
                        end
                    end
                end
                chk("o_val", 32'(o_val), 32'(have && i_val[g]));
                chk("i_rdy", 32'(i_rdy), (have && o_rdy) ? (32'd1 << g) : 32'd0);
                if (have && i_val[g] && exp_q[g].size() > 0) begin
                    head = exp_q[g][0];
                    chk("o_chn", 32'(o_chn), 32'(g));
                    chk("o_dat", 32'(o_dat), 32'(head[WIDTH-1:0]));
                    chk("o_eop", 32'(o_eop), 32'(head[WIDTH]));
                    chk("o_sop", 32'(o_sop), 32'(first));
                    if (o_rdy) begin
                        void'(exp_q[g].pop_front());
                        acc_mask = INPUTS'(1) << g;
                        beats++;
                        first = head[WIDTH];
                        if (head[WIDTH]) begin
                            in_pkt  = 1'b0;
                            last_ch = g;
                        end else begin
                            in_pkt = 1'b1;
                            owner  = g;
                        end
                    end else begin
                        in_pkt = 1'b1;
                        owner  = g;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bit busy;
        int len;
        logic [WIDTH:0] b;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            busy = (cyc >= CYCLES / 2);
            for (int k = 0; k < INPUTS; k++) begin
                if (acc_mask[k]) void'(src_q[k].pop_front());
            end
            reset = (cyc < 20) || ($urandom % 250 != 0);
            for (int k = 0; k < INPUTS; k++) begin
                if (!(i_val[k] && !acc_mask[k])) begin
                    if (src_q[k].size() == 0 && (busy || $urandom % 4 == 0) && cyc > 10) begin
                        len = busy ? 2 : int'($urandom_range(1, 4));
                        for (int n = 0; n < len; n++) begin
                            b = {(n == len - 1), WIDTH'($urandom)};
                            src_q[k].push_back(b);
                            exp_q[k].push_back(b);
                        end
                    end
                    i_val[k] = (src_q[k].size() > 0) && (busy || $urandom % 4 != 0);
                    if (src_q[k].size() > 0) begin
                        i_dat[k*WIDTH +: WIDTH] = src_q[k][0][WIDTH-1:0];
                        i_eop[k]                = src_q[k][0][WIDTH];
                    end
                end
            end
            o_rdy = busy ? 1'b1 : ($urandom % 4 != 0);
        end
        @(negedge clk);
        checks++;
        if (beats < 500) begin
            errors++;
            $display("FAIL beat_count: got %0d expected at least 500", beats);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
